// File: rtl/bcd_add_seq.sv
// Sequential NDIG-digit BCD adder with a seven-segment result display.
// Latency: done pulses NDIG+2 cycles after start is accepted (2 cycles for an illegal digit).
// Backpressure: start is honoured only in IDLE; it is ignored while busy, with no queueing.
module bcd_add_seq #(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    cin,
  input  logic [4*NDIG-1:0]       a,
  input  logic [4*NDIG-1:0]       b,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [4*NDIG-1:0]       sum,
  output logic                    cout,
  output logic [7*(NDIG+1)-1:0]   hex
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;

  state_t            state;
  state_t            state_nx;
  logic [4*NDIG-1:0] a_q;
  logic [4*NDIG-1:0] b_q;
  logic [4*NDIG-1:0] acc;
  logic              carry;
  logic              bad_q;
  logic [3:0]        idx;
  logic              bad_digit;
  logic              last_dig;
  logic [3:0]        a_dig;
  logic [3:0]        b_dig;
  logic [4:0]        t;
  logic [4:0]        t6;
  logic [3:0]        s_dig;
  logic              c_dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  assign busy     = (state != IDLE);
  assign last_dig = (idx == 4'(NDIG-1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = bad_digit ? DONE : ADD;
      ADD:     if (last_dig) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Flag any latched operand digit outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One decimal digit add with +6 correction for the current index.
  always_comb begin
    a_dig = a_q[4*idx +: 4];
    b_dig = b_q[4*idx +: 4];
    t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry};
    t6    = t + 5'd6;
    if (t > 5'd9) begin
      s_dig = t6[3:0];
      c_dig = 1'b1;
    end else begin
      s_dig = t[3:0];
      c_dig = 1'b0;
    end
  end

  // Operand capture and digit-serial accumulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      bad_q <= 1'b0;
      idx   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
          end
        end
        CHECK: begin
          bad_q <= bad_digit;
          idx   <= 4'd0;
          acc   <= '0;
        end
        ADD: begin
          acc[4*idx +: 4] <= s_dig;
          carry           <= c_dig;
          idx             <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load only on leaving DONE; done marks that update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum  <= '0;
      cout <= 1'b0;
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        sum  <= bad_q ? '0 : acc;
        cout <= bad_q ? 1'b0 : carry;
        err  <= bad_q;
      end
    end
  end

  // Display decode from the registered result.
  always_comb begin
    hex = '1;
    for (int i = 0; i < NDIG; i++) begin
      hex[7*i +: 7] = err ? GLYPH_E : seg7(sum[4*i +: 4]);
    end
    hex[7*NDIG +: 7] = err ? GLYPH_BLANK : (cout ? GLYPH_1 : GLYPH_0);
  end

endmodule

// File: tb/tb_bcd_add_seq.sv
// Directed bench for bcd_add_seq with NDIG=4.
// Checks reset state, sums, carries, illegal digits, ignored starts, back-to-back and mid-op reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_add_seq;
  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sum;
  logic        cout;
  logic [34:0] hex;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_sum;
  logic        prev_cout;
  logic        prev_err;

  bcd_add_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .sum(sum), .cout(cout), .hex(hex)
  );

  always #5 clk = ~clk;

  // Starts at a falling edge; returns at the falling edge where done is seen.
  task automatic run_add(input string name, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic [15:0] esum, input logic ecout,
                         input logic eerr, input logic [34:0] ehex, input int elat,
                         input bit disturb);
    int k;
    bit seen;
    a = ia; b = ib; cin = icin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    seen = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    checks++;
    if (sum !== prev_sum || cout !== prev_cout || err !== prev_err) begin
      failures++;
      $display("FAIL %s hold_while_busy: sum=%h cout=%b err=%b required sum=%h cout=%b err=%b",
               name, sum, cout, err, prev_sum, prev_cout, prev_err);
    end
    while (!seen && k < 20) begin
      if (disturb && k == 2) begin
        start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b1;
      end else if (disturb && k == 3) begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k != elat) begin
      failures++;
      $display("FAIL %s latency: seen=%0d cycles=%0d required %0d", name, seen, k, elat);
    end
    checks++;
    if (sum !== esum || cout !== ecout || err !== eerr) begin
      failures++;
      $display("FAIL %s result: sum=%h cout=%b err=%b required sum=%h cout=%b err=%b",
               name, sum, cout, err, esum, ecout, eerr);
    end
    checks++;
    if (hex !== ehex) begin
      failures++;
      $display("FAIL %s hex: got %h required %h", name, hex, ehex);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    end
    prev_sum = esum; prev_cout = ecout; prev_err = eerr;
  endtask

  task automatic test_reset();
    resetn = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cout !== 1'b0 || sum !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b cout=%b sum=%h required all zero",
               busy, done, err, cout, sum);
    end
    checks++;
    if (hex !== {5{7'h40}}) begin
      failures++;
      $display("FAIL reset_hex: got %h required %h", hex, {5{7'h40}});
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    prev_sum = '0; prev_cout = 1'b0; prev_err = 1'b0;
  endtask

  task automatic test_basic();
    run_add("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0,
            {7'h40, 7'h02, 7'h10, 7'h79, 7'h24}, 6, 1'b0);
    run_add("add_0999_0001_c1", 16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0,
            {7'h40, 7'h79, 7'h40, 7'h40, 7'h79}, 6, 1'b0);
  endtask

  task automatic test_carry();
    run_add("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0,
            {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 6, 1'b0);
    run_add("add_0000_0000_c1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0,
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h79}, 6, 1'b0);
    run_add("add_9999_9999_c1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0,
            {7'h79, 7'h10, 7'h10, 7'h10, 7'h10}, 6, 1'b0);
    run_add("add_5555_4445", 16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b0,
            {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, 6, 1'b0);
  endtask

  task automatic test_error();
    run_add("err_a_12A4", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1,
            {7'h7F, 7'h06, 7'h06, 7'h06, 7'h06}, 2, 1'b0);
    run_add("err_b_F000_c1", 16'h0123, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1,
            {7'h7F, 7'h06, 7'h06, 7'h06, 7'h06}, 2, 1'b0);
    run_add("err_clears", 16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0,
            {7'h40, 7'h12, 7'h12, 7'h12, 7'h12}, 6, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_add("ignore_busy_start", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0,
            {7'h40, 7'h02, 7'h10, 7'h79, 7'h24}, 6, 1'b1);
    run_add("back_to_back", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0,
            {7'h40, 7'h40, 7'h40, 7'h79, 7'h40}, 6, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    run_add("err_before_reset", 16'hB000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1,
            {7'h7F, 7'h06, 7'h06, 7'h06, 7'h06}, 2, 1'b0);
    run_add("nonzero_before_reset", 16'h0042, 16'h0000, 1'b0, 16'h0042, 1'b0, 1'b0,
            {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 6, 1'b0);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before: got %b required 1", busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cout !== 1'b0 || sum !== 16'h0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b done=%b err=%b cout=%b sum=%h required all zero",
               busy, done, err, cout, sum);
    end
    checks++;
    if (hex !== {5{7'h40}}) begin
      failures++;
      $display("FAIL midreset_hex: got %h required %h", hex, {5{7'h40}});
    end
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midreset_no_done: done seen=1 required 0");
    end
    resetn = 1'b1;
    prev_sum = '0; prev_cout = 1'b0; prev_err = 1'b0;
    run_add("after_reset_0005_0005", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0,
            {7'h40, 7'h40, 7'h40, 7'h79, 7'h40}, 6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
